// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared constants and grant encoding for the CPU bus arbiter.
package cpu_bus_arbiter_pkg;

   localparam logic       OWNER_INST = 1'b0;
   localparam logic       OWNER_DATA = 1'b1;
   localparam logic [1:0] SIZE_WORD  = 2'd2;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_INST,
      GNT_DATA
   } gnt_e;

endpackage

// File: rtl/cpu_bus_arbiter_ofifo.sv
// In-order outstanding-transaction FIFO.
// Each entry holds an owner bit and a discard bit.
module cpu_bus_arbiter_ofifo
   import cpu_bus_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic push_owner_i,
   input  logic push_disc_i,
   input  logic pop_i,
   input  logic kill_i,
   output logic full_o,
   output logic empty_o,
   output logic head_owner_o,
   output logic head_disc_o
);

   logic [DEPTH-1:0] owner_q, owner_d;
   logic [DEPTH-1:0] disc_q, disc_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push;
   logic             pop;

   // DEPTH is a power of two, so the top count bit means full.
   assign full_o       = cnt_q[AW];
   assign empty_o      = (cnt_q == '0);
   assign push         = push_i && !full_o;
   assign pop          = pop_i && !empty_o;
   assign head_owner_o = owner_q[rd_ptr_q];
   assign head_disc_o  = disc_q[rd_ptr_q];

   always_comb begin
      owner_d  = owner_q;
      disc_d   = disc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Free slots get marked too; a push rewrites both bits anyway.
      if (kill_i) begin
         disc_d = disc_q | ~owner_q;
      end
      if (push) begin
         owner_d[wr_ptr_q] = push_owner_i;
         disc_d[wr_ptr_q]  = push_disc_i;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= '0;
         disc_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         owner_q  <= owner_d;
         disc_q   <= disc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and data ports,
// routing in-order responses back and dropping flushed fetches.
module cpu_bus_arbiter
   import cpu_bus_arbiter_pkg::*;
#(
   parameter int OUTST_DEPTH = 4,
   parameter int OUTST_AW    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   gnt_e gnt;
   logic full;
   logic empty;
   logic head_owner;
   logic head_disc;
   logic push;
   logic pop;
   logic resp;

   always_comb begin
      gnt = GNT_NONE;
      if (!reset && !full) begin
         if (data_req) begin
            gnt = GNT_DATA;
         end else if (inst_req) begin
            gnt = GNT_INST;
         end
      end
   end

   always_comb begin
      bus_req   = (gnt != GNT_NONE);
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
      if (gnt == GNT_INST) begin
         bus_wr    = 1'b0;
         bus_size  = SIZE_WORD;
         bus_wstrb = '0;
         bus_addr  = inst_addr;
         bus_wdata = '0;
      end
   end

   assign inst_addr_ok = bus_addr_ok && (gnt == GNT_INST);
   assign data_addr_ok = bus_addr_ok && (gnt == GNT_DATA);

   assign push = bus_req && bus_addr_ok;
   assign pop  = bus_data_ok && !reset;
   assign resp = pop && !empty;

   // A head fetch popped during flush is dropped like older ones.
   assign data_data_ok = resp && (head_owner == OWNER_DATA);
   assign inst_data_ok = resp && (head_owner == OWNER_INST)
                       && !head_disc && !flush;
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

   cpu_bus_arbiter_ofifo #(
      .DEPTH (OUTST_DEPTH),
      .AW    (OUTST_AW)
   ) u_ofifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_owner_i ((gnt == GNT_DATA) ? OWNER_DATA : OWNER_INST),
      .push_disc_i  (flush && (gnt == GNT_INST)),
      .pop_i        (pop),
      .kill_i       (flush && !reset),
      .full_o       (full),
      .empty_o      (empty),
      .head_owner_o (head_owner),
      .head_disc_o  (head_disc)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && bus_data_ok) begin
         assert (!empty)
         else $error("bus_data_ok with no outstanding transaction");
      end
   end
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter.
module tb_cpu_bus_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   typedef struct {
      bit own;
      bit disc;
   } ent_t;

   ent_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   cpu_bus_arbiter #(.OUTST_DEPTH(DEPTH), .OUTST_AW(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .bus_req      (bus_req),
      .bus_wr       (bus_wr),
      .bus_size     (bus_size),
      .bus_wstrb    (bus_wstrb),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_addr_ok  (bus_addr_ok),
      .bus_data_ok  (bus_data_ok),
      .bus_rdata    (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle, check against the model, then advance.
   task automatic step(input bit ir, input bit dr, input bit dw,
                       input bit aok, input bit dok, input bit fl,
                       input logic [31:0] rd);
      bit   full, gi, gd, ei;
      ent_t e;
      inst_req    = ir;
      data_req    = dr;
      data_wr     = dw;
      bus_addr_ok = aok;
      bus_data_ok = dok;
      flush       = fl;
      bus_rdata   = rd;
      #2;
      full = (sb.size() == DEPTH);
      gd   = !full && dr;
      gi   = !full && ir && !dr;
      chk("bus_req", bus_req, gi || gd);
      chk("inst_addr_ok", inst_addr_ok, aok && gi);
      chk("data_addr_ok", data_addr_ok, aok && gd);
      if (gi) begin
         chk("i_bus_addr", bus_addr, inst_addr);
         chk("i_bus_wr", bus_wr, 0);
         chk("i_bus_size", bus_size, 2);
         chk("i_bus_wstrb", bus_wstrb, 0);
      end
      if (gd) begin
         chk("d_bus_addr", bus_addr, data_addr);
         chk("d_bus_wr", bus_wr, dw);
         chk("d_bus_wstrb", bus_wstrb, data_wstrb);
         chk("d_bus_wdata", bus_wdata, data_wdata);
      end
      if (dok && sb.size() > 0) begin
         e  = sb.pop_front();
         ei = !e.own && !e.disc && !fl;
         chk("inst_data_ok", inst_data_ok, ei);
         chk("data_data_ok", data_data_ok, e.own);
         if (ei) chk("inst_rdata", inst_rdata, rd);
         if (e.own) chk("data_rdata", data_rdata, rd);
      end else begin
         chk("idle_inst_dok", inst_data_ok, 0);
         chk("idle_data_dok", data_data_ok, 0);
      end
      if (fl) begin
         foreach (sb[i]) if (!sb[i].own) sb[i].disc = 1'b1;
      end
      if ((gi || gd) && aok) sb.push_back('{gd, fl && gi});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      inst_req    = 1'b1;
      data_req    = 1'b1;
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b1;
      flush       = 1'b0;
      #2;
      chk("rst_bus_req", bus_req, 0);
      chk("rst_iaok", inst_addr_ok, 0);
      chk("rst_daok", data_addr_ok, 0);
      chk("rst_idok", inst_data_ok, 0);
      chk("rst_ddok", data_data_ok, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      inst_req    = 1'b0;
      inst_addr   = 32'h1c00_0000;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_size   = 2'd2;
      data_wstrb  = 4'h0;
      data_addr   = 32'h0;
      data_wdata  = 32'h0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'h0;
      @(posedge clk);
      #1;
      do_reset();

      // single fetch, one-cycle response
      inst_addr = 32'h1c00_0000;
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(0, 0, 0, 1, 1, 0, 32'h0280_0000);

      // data beats inst, then inst granted
      data_addr  = 32'h1c00_8000;
      data_wdata = 32'hdead_beef;
      data_wstrb = 4'hf;
      inst_addr  = 32'h1c00_0004;
      step(1, 1, 1, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(0, 0, 0, 1, 1, 0, 32'h0);
      step(0, 0, 0, 1, 1, 0, 32'h1111_2222);

      // fill to depth, stall, pop one, refill
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h1c00_0100 + 4 * i;
         step(1, 0, 0, 1, 0, 0, 32'h0);
      end
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 1, 0, 32'hA0A0_0001);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 1, 1, 0, 32'hB0B0_0000 + i);

      // flush with two fetches and a load outstanding
      data_wstrb = 4'h0;
      data_addr  = 32'h1c00_9000;
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(0, 1, 0, 1, 0, 0, 32'h0);
      step(0, 0, 0, 1, 0, 1, 32'h0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 1, 1, 0, 32'hC0C0_0000 + i);

      // flush with same-cycle push and head pop
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 1, 1, 32'hD0D0_0000);
      step(0, 0, 0, 1, 1, 0, 32'hD0D0_0001);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(0, 0, 0, 1, 1, 0, 32'hD0D0_0002);

      // reset with load at head abandons entries
      step(0, 1, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      do_reset();
      step(1, 0, 0, 1, 0, 0, 32'h0);
      step(0, 0, 0, 1, 1, 0, 32'hE0E0_0000);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         inst_addr  = $urandom;
         data_addr  = $urandom;
         data_wdata = $urandom;
         data_wstrb = 4'($urandom);
         data_size  = 2'($urandom_range(0, 2));
         step(1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0),
              (sb.size() > 0) && ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) == 0), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
